// File: rtl/fso_deframer.sv
// FSO receive deframer: hunts for the SYNC word, verifies a run of good frames, then emits payload with flywheel loss handling.
// Optional PRBS15 payload descrambler is compiled in when FSO_DEFRAMER_DESCRAMBLE_EN is defined.
module fso_deframer #(
    parameter int              W                = 32,
    parameter int              PAYLOAD_WORDS    = 16,
    parameter int              FRAMES_PER_BLOCK = 255,
    parameter logic [W-1:0]    SYNC_WORD        = 32'h1ACFFC1D,
    parameter int              LOCK_FRAMES      = 3,
    parameter int              LOSS_FRAMES      = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [W-1:0]  i_rx_data,
    input  logic          i_rx_valid,
    output logic          o_rx_ready,
    input  logic          i_descrambler_en,
    output logic [W-1:0]  o_payload_data,
    output logic          o_payload_valid,
    output logic          o_payload_block_start,
    input  logic          i_payload_ready,
    output logic          o_locked,
    output logic [15:0]   o_frame_in_block,
    output logic [15:0]   o_block_id,
    output logic [15:0]   o_frame_index,
    output logic [15:0]   o_sync_err_cnt
);

    localparam int            PW       = $clog2(PAYLOAD_WORDS + 2);
    localparam logic [PW-1:0] POS_LAST = PW'(PAYLOAD_WORDS + 1);
    localparam logic [15:0]   FPB      = 16'(FRAMES_PER_BLOCK);
    localparam logic [7:0]    LOCK_N   = 8'(LOCK_FRAMES);
    localparam logic [7:0]    LOSS_N   = 8'(LOSS_FRAMES);

    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

    state_t        state, state_next;
    logic [PW-1:0] pos, pos_next, pos_inc;
    logic [7:0]    good, good_next;
    logic [7:0]    miss, miss_next;
    logic          sync_ok, sync_ok_next;
    logic          xfer, is_sync, fib_ok;
    logic          emit, hdr_load, frame_good, err_inc;
    logic [W-1:0]  keystream;

    assign o_rx_ready = rst_n && (!o_payload_valid || i_payload_ready);
    assign xfer       = i_rx_valid && o_rx_ready;
    assign is_sync    = (i_rx_data == SYNC_WORD);
    assign fib_ok     = (i_rx_data[15:0] < FPB);
    assign pos_inc    = (pos == POS_LAST) ? '0 : pos + PW'(1);
    assign o_locked   = (state == LOCKED);

    always_comb begin
        state_next   = state;
        pos_next     = pos;
        good_next    = good;
        miss_next    = miss;
        sync_ok_next = sync_ok;
        emit         = 1'b0;
        hdr_load     = 1'b0;
        frame_good   = 1'b0;
        err_inc      = 1'b0;
        if (xfer) begin
            case (state)
                HUNT: begin
                    if (is_sync) begin
                        state_next   = VERIFY;
                        pos_next     = PW'(1);
                        good_next    = 8'd1;
                        sync_ok_next = 1'b1;
                    end
                end
                VERIFY: begin
                    pos_next = pos_inc;
                    if (pos == '0) begin
                        if (is_sync) begin
                            sync_ok_next = 1'b1;
                            good_next    = good + 8'd1;
                        end else begin
                            state_next = HUNT;
                            pos_next   = '0;
                        end
                    end else if (pos == PW'(1)) begin
                        hdr_load = 1'b1;
                        if (sync_ok && fib_ok) begin
                            frame_good = 1'b1;
                        end else begin
                            state_next = HUNT;
                            pos_next   = '0;
                        end
                    end else if (pos == POS_LAST && good >= LOCK_N) begin
                        // Lock takes effect at a frame boundary so emission starts on a whole frame.
                        state_next = LOCKED;
                        miss_next  = 8'd0;
                    end
                end
                LOCKED: begin
                    pos_next = pos_inc;
                    if (pos == '0) begin
                        sync_ok_next = is_sync;
                    end else if (pos == PW'(1)) begin
                        hdr_load = 1'b1;
                        if (sync_ok && fib_ok) begin
                            frame_good = 1'b1;
                            miss_next  = 8'd0;
                        end else begin
                            err_inc   = 1'b1;
                            miss_next = miss + 8'd1;
                            if (miss + 8'd1 >= LOSS_N) begin
                                state_next = HUNT;
                                pos_next   = '0;
                                miss_next  = 8'd0;
                            end
                        end
                    end else begin
                        emit = 1'b1;
                    end
                end
                default: begin
                    state_next = HUNT;
                    pos_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                 <= HUNT;
            pos                   <= '0;
            good                  <= 8'd0;
            miss                  <= 8'd0;
            sync_ok               <= 1'b0;
            o_payload_data        <= '0;
            o_payload_valid       <= 1'b0;
            o_payload_block_start <= 1'b0;
            o_frame_in_block      <= 16'd0;
            o_block_id            <= 16'd0;
            o_frame_index         <= 16'd0;
            o_sync_err_cnt        <= 16'd0;
        end else begin
            state   <= state_next;
            pos     <= pos_next;
            good    <= good_next;
            miss    <= miss_next;
            sync_ok <= sync_ok_next;
            if (hdr_load) begin
                o_block_id       <= i_rx_data[31:16];
                o_frame_in_block <= i_rx_data[15:0];
            end
            if (frame_good)
                o_frame_index <= o_frame_index + 16'd1;
            if (err_inc && o_sync_err_cnt != 16'hFFFF)
                o_sync_err_cnt <= o_sync_err_cnt + 16'd1;
            // emit only happens when the output register is free or draining this cycle.
            if (emit) begin
                o_payload_valid       <= 1'b1;
                o_payload_data        <= i_rx_data ^ keystream;
                o_payload_block_start <= (pos == PW'(2)) && (o_frame_in_block == 16'd0);
            end else if (i_payload_ready) begin
                o_payload_valid       <= 1'b0;
                o_payload_block_start <= 1'b0;
            end
        end
    end

`ifdef FSO_DEFRAMER_DESCRAMBLE_EN
    logic [14:0]  lfsr, lfsr_adv;
    logic [W-1:0] ks_word;
    logic         descr_en;

    // PRBS15 x^15+x^14+1, 32 steps per word, first generated bit lands in the MSB.
    always_comb begin
        logic [14:0] s;
        logic        b;
        s       = lfsr;
        b       = 1'b0;
        ks_word = '0;
        for (int i = W - 1; i >= 0; i--) begin
            b          = s[14] ^ s[13];
            ks_word[i] = b;
            s          = {s[13:0], b};
        end
        lfsr_adv = s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr     <= 15'h7FFF;
            descr_en <= 1'b0;
        end else if (hdr_load) begin
            lfsr     <= 15'h7FFF;
            descr_en <= i_descrambler_en;
        end else if (emit) begin
            lfsr <= lfsr_adv;
        end
    end

    assign keystream = descr_en ? ks_word : '0;
`else
    logic unused_descr_en;
    assign unused_descr_en = i_descrambler_en;
    assign keystream       = '0;
`endif

endmodule
